// File: rtl/cache_pkg.sv
// Shared cache geometry constants and the refill/writeback sequencer state encoding.
package cache_pkg;

    localparam int NUM_SETS      = 128;
    localparam int ASSOCIATIVITY = 4;
    localparam int BLOCK_SIZE    = 64;
    localparam int WORD_SIZE     = 4;
    localparam int INDEX_W       = 7;
    localparam int TAG_W         = 19;

    typedef enum logic [2:0] {
        IDLE,
        WB_RD,
        WB_CAP,
        WB_MEM,
        FL_MEM,
        FL_WR,
        DONE
    } rwb_state_t;

endpackage

// File: rtl/refill_writeback_unit.sv
// Miss service sequencer: writes back a dirty victim line word by word, then fetches
// the new line from memory and installs it in the data array, pulsing done at the end.
module refill_writeback_unit #(
    parameter int WORDS_PER_BLOCK = 16,
    parameter int TAG_W           = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [6:0]       req_set,
    input  logic [1:0]       req_way,
    input  logic             req_dirty,
    input  logic [TAG_W-1:0] req_victim_tag,
    input  logic [TAG_W-1:0] req_fill_tag,
    output logic             done,
    output logic             mem_req,
    output logic             mem_we,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_wdata,
    input  logic             mem_ack,
    input  logic [31:0]      mem_rdata,
    output logic [6:0]       da_set_index,
    output logic [1:0]       da_way,
    output logic [5:0]       da_block_offset,
    output logic [31:0]      da_write_data,
    input  logic [31:0]      da_read_data,
    output logic             da_read,
    output logic             da_write
);
    import cache_pkg::*;

    localparam logic [3:0] LAST_K = 4'(WORDS_PER_BLOCK - 1);

    rwb_state_t       state_reg, state_next;
    logic [3:0]       k_reg, k_next;
    logic [6:0]       set_reg;
    logic [1:0]       way_reg;
    logic [TAG_W-1:0] victim_tag_reg;
    logic [TAG_W-1:0] fill_tag_reg;
    logic [31:0]      wbuf_reg;
    logic [31:0]      fbuf_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= IDLE;
            k_reg          <= '0;
            set_reg        <= '0;
            way_reg        <= '0;
            victim_tag_reg <= '0;
            fill_tag_reg   <= '0;
            wbuf_reg       <= '0;
            fbuf_reg       <= '0;
        end else begin
            state_reg <= state_next;
            k_reg     <= k_next;
            if (state_reg == IDLE && req_valid) begin
                set_reg        <= req_set;
                way_reg        <= req_way;
                victim_tag_reg <= req_victim_tag;
                fill_tag_reg   <= req_fill_tag;
            end
            // Array read data arrives one cycle after the WB_RD strobe
            if (state_reg == WB_CAP)
                wbuf_reg <= da_read_data;
            if (state_reg == FL_MEM && mem_ack)
                fbuf_reg <= mem_rdata;
        end
    end

    always_comb begin
        state_next      = state_reg;
        k_next          = k_reg;
        req_ready       = 1'b0;
        done            = 1'b0;
        mem_req         = 1'b0;
        mem_we          = 1'b0;
        mem_addr        = '0;
        mem_wdata       = '0;
        da_read         = 1'b0;
        da_write        = 1'b0;
        da_set_index    = '0;
        da_way          = '0;
        da_block_offset = '0;
        da_write_data   = '0;

        case (state_reg)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    k_next     = '0;
                    state_next = req_dirty ? WB_RD : FL_MEM;
                end
            end
            WB_RD: begin
                da_read    = 1'b1;
                state_next = WB_CAP;
            end
            WB_CAP: begin
                state_next = WB_MEM;
            end
            WB_MEM: begin
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = 32'({victim_tag_reg, set_reg, k_reg, 2'b00});
                mem_wdata = wbuf_reg;
                if (mem_ack) begin
                    if (k_reg == LAST_K) begin
                        k_next     = '0;
                        state_next = FL_MEM;
                    end else begin
                        k_next     = k_reg + 4'd1;
                        state_next = WB_RD;
                    end
                end
            end
            FL_MEM: begin
                mem_req  = 1'b1;
                mem_addr = 32'({fill_tag_reg, set_reg, k_reg, 2'b00});
                if (mem_ack)
                    state_next = FL_WR;
            end
            FL_WR: begin
                da_write      = 1'b1;
                da_write_data = fbuf_reg;
                if (k_reg == LAST_K) begin
                    state_next = DONE;
                end else begin
                    k_next     = k_reg + 4'd1;
                    state_next = FL_MEM;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase

        if (state_reg != IDLE) begin
            da_set_index    = set_reg;
            da_way          = way_reg;
            da_block_offset = {k_reg, 2'b00};
        end

        // Outputs go quiet as soon as reset is seen, before the state register clears
        if (rst) begin
            req_ready       = 1'b0;
            done            = 1'b0;
            mem_req         = 1'b0;
            mem_we          = 1'b0;
            mem_addr        = '0;
            mem_wdata       = '0;
            da_read         = 1'b0;
            da_write        = 1'b0;
            da_set_index    = '0;
            da_way          = '0;
            da_block_offset = '0;
            da_write_data   = '0;
        end
    end

endmodule

// File: tb/tb_refill_writeback_unit.sv
// Scoreboard bench for refill_writeback_unit: expected memory beats, array writes and
// done pulses are queued at issue time and checked by an independent monitor.
module tb_refill_writeback_unit;

    localparam logic [1:0] EV_MWR  = 2'd0;
    localparam logic [1:0] EV_MRD  = 2'd1;
    localparam logic [1:0] EV_DAW  = 2'd2;
    localparam logic [1:0] EV_DONE = 2'd3;

    typedef struct {
        logic [1:0]  kind;
        logic [31:0] addr;
        logic [31:0] data;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [6:0]  req_set;
    logic [1:0]  req_way;
    logic        req_dirty;
    logic [18:0] req_victim_tag;
    logic [18:0] req_fill_tag;
    logic        done;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [6:0]  da_set_index;
    logic [1:0]  da_way;
    logic [5:0]  da_block_offset;
    logic [31:0] da_write_data;
    logic [31:0] da_read_data;
    logic        da_read;
    logic        da_write;

    int  vectors = 0;
    int  miscompares = 0;
    int  cyc = 0;
    int  accept_cyc = 0;
    int  daw_cnt = 0;
    bit  busy = 0;
    bit  mem_en = 1;
    int  wait_cycles = 0;
    ev_t exp_q[$];

    refill_writeback_unit #(.WORDS_PER_BLOCK(16), .TAG_W(19)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_set(req_set), .req_way(req_way), .req_dirty(req_dirty),
        .req_victim_tag(req_victim_tag), .req_fill_tag(req_fill_tag),
        .done(done),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .da_set_index(da_set_index), .da_way(da_way), .da_block_offset(da_block_offset),
        .da_write_data(da_write_data), .da_read_data(da_read_data),
        .da_read(da_read), .da_write(da_write)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        vectors++;
        if (act !== expv) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, expv, $time);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [31:0] addr, input logic [31:0] data);
        ev_t e;
        e.kind = kind;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Memory and data-array responders: ack after wait_cycles stall cycles, fill data is addr^5A5A0000,
    // array word k of the victim line reads as A000_0000+k.
    initial begin
        logic       rd_pend;
        logic [5:0] rd_off;
        int         wcnt;
        mem_ack = 1'b0;
        mem_rdata = '0;
        da_read_data = '0;
        wcnt = 0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (mem_req) begin
                    wcnt++;
                    if (wcnt > wait_cycles) begin
                        mem_ack = 1'b1;
                        mem_rdata = mem_addr ^ 32'h5A5A_0000;
                        wcnt = 0;
                    end else begin
                        mem_ack = 1'b0;
                    end
                end else begin
                    mem_ack = 1'b0;
                    wcnt = 0;
                end
            end
            rd_pend = da_read;
            rd_off = da_block_offset;
            @(posedge clk);
            #1;
            if (rd_pend)
                da_read_data = 32'hA000_0000 + {28'd0, rd_off[5:2]};
        end
    end

    // Monitor: pops the scoreboard on every observable event and checks protocol invariants.
    initial begin
        bit          pend = 0;
        logic [31:0] p_addr, p_wdata;
        logic        p_we;
        ev_t         obs, e;
        bit          have;
        forever begin
            @(negedge clk);
            #2;
            cyc++;
            if (rst) begin
                busy = 0;
                pend = 0;
                continue;
            end
            if (da_read && da_write) begin
                vectors++; miscompares++;
                $display("FAIL rd_wr_overlap: da_read=1 da_write=1 required not both");
            end
            if (busy && req_ready) begin
                vectors++; miscompares++;
                $display("FAIL busy_ready: req_ready=1 required 0 during transaction");
            end
            if (pend) begin
                if (!mem_req) begin
                    vectors++; miscompares++;
                    $display("FAIL req_dropped: mem_req=0 required 1 before ack");
                end else begin
                    check("stall_addr", mem_addr, p_addr);
                    check("stall_we", {31'd0, mem_we}, {31'd0, p_we});
                    check("stall_wdata", mem_wdata, p_wdata);
                end
            end
            pend = mem_req && !mem_ack;
            p_addr = mem_addr;
            p_we = mem_we;
            p_wdata = mem_wdata;

            have = 0;
            if (mem_req && mem_ack) begin
                have = 1;
                obs.kind = mem_we ? EV_MWR : EV_MRD;
                obs.addr = mem_addr;
                obs.data = mem_we ? mem_wdata : 32'd0;
            end else if (da_write) begin
                have = 1;
                daw_cnt++;
                obs.kind = EV_DAW;
                obs.addr = {17'd0, da_set_index, da_way, da_block_offset};
                obs.data = da_write_data;
            end else if (done) begin
                have = 1;
                obs.kind = EV_DONE;
                obs.addr = 32'd0;
                obs.data = 32'(cyc - accept_cyc);
                busy = 0;
            end
            if (have) begin
                if (exp_q.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_event: kind=%0d addr=%h required none", obs.kind, obs.addr);
                end else begin
                    e = exp_q.pop_front();
                    check("event_kind", {30'd0, obs.kind}, {30'd0, e.kind});
                    check("event_addr", obs.addr, e.addr);
                    if (e.kind != EV_DONE || e.data != 0)
                        check("event_data", obs.data, e.data);
                end
            end
            if (req_valid && req_ready) begin
                busy = 1;
                accept_cyc = cyc;
            end
        end
    end

    // Queue expectations for one transaction (nwords fill words) and present the request.
    task automatic issue(input logic [6:0] set, input logic [1:0] way, input logic dirty,
                         input logic [18:0] vt, input logic [18:0] ft,
                         input logic [31:0] wb_base, input logic [31:0] fl_base,
                         input int lat, input int nwords, input bit hold);
        int n;
        if (dirty)
            for (int k = 0; k < 16; k++)
                push(EV_MWR, wb_base + 32'(4 * k), 32'hA000_0000 + 32'(k));
        for (int k = 0; k < nwords; k++) begin
            push(EV_MRD, fl_base + 32'(4 * k), 32'd0);
            push(EV_DAW, {17'd0, set, way, 6'(4 * k)}, (fl_base + 32'(4 * k)) ^ 32'h5A5A_0000);
        end
        if (nwords == 16)
            push(EV_DONE, 32'd0, 32'(lat));
        @(negedge clk);
        req_valid = 1'b1;
        req_set = set;
        req_way = way;
        req_dirty = dirty;
        req_victim_tag = vt;
        req_fill_tag = ft;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            vectors++; miscompares++;
            $display("FAIL accept_timeout: req_ready=0 required 1");
        end
        if (!hold) begin
            @(posedge clk);
            #1 req_valid = 1'b0;
        end else begin
            n = 0;
            @(negedge clk);
            while (!done && n < 3000) begin
                @(negedge clk);
                n++;
            end
            req_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        vectors++;
        if (exp_q.size() != 0 || busy) begin
            miscompares++;
            $display("FAIL %s_timeout: %0d events outstanding required 0", name, exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        req_valid = 1'b0;
        req_set = '0;
        req_way = '0;
        req_dirty = 1'b0;
        req_victim_tag = '0;
        req_fill_tag = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_mem_req", {31'd0, mem_req}, 32'd0);
        check("rst_da_strobes", {30'd0, da_read, da_write}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        check("rst_done", {31'd0, done}, 32'd0);

        // Clean fill, zero-wait memory
        issue(7'd5, 2'd2, 1'b0, 19'h0, 19'h1, 32'h0, 32'h0000_2140, 33, 16, 0);
        drain("clean");
        $display("clean fill set=5 way=2 done");

        // Dirty miss, zero-wait memory
        issue(7'd5, 2'd1, 1'b1, 19'h7FFFF, 19'h00123, 32'hFFFF_E140, 32'h0024_6140, 81, 16, 0);
        drain("dirty");
        $display("dirty miss victim=7FFFF done");

        // Dirty miss with three stall cycles per beat
        wait_cycles = 3;
        issue(7'h7F, 2'd3, 1'b1, 19'h00001, 19'h40000, 32'h0000_3FC0, 32'h8000_1FC0, 0, 16, 0);
        drain("stall");
        $display("stalled dirty miss set=7F way=3 done");
        wait_cycles = 0;

        // req_valid held through the transaction
        issue(7'd3, 2'd0, 1'b0, 19'h0, 19'h00010, 32'h0, 32'h0002_00C0, 33, 16, 1);
        drain("backpressure");
        $display("back-pressure fill set=3 done");

        // Reset while the fill is stalled on word 7
        wait_cycles = 3;
        base = daw_cnt;
        issue(7'd5, 2'd2, 1'b0, 19'h0, 19'h1, 32'h0, 32'h0000_2140, 0, 7, 0);
        while (daw_cnt - base < 7) @(negedge clk);
        rst = 1'b1;
        #1;
        check("midrst_strobes", {28'd0, mem_req, da_read, da_write, done}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        check("postrst_ready", {31'd0, req_ready}, 32'd1);
        check("postrst_strobes", {28'd0, mem_req, da_read, da_write, done}, 32'd0);
        repeat (10) @(negedge clk);
        check("postrst_queue", 32'(exp_q.size()), 32'd0);
        wait_cycles = 0;
        issue(7'd9, 2'd0, 1'b0, 19'h0, 19'h2, 32'h0, 32'h0000_4240, 33, 16, 0);
        drain("after_reset");
        $display("reset at fill word 7 and recovery fill done");

        // Spurious ack in IDLE
        mem_en = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            mem_ack = 1'b1;
            mem_rdata = 32'hDEAD_BEEF;
            @(posedge clk);
            #1;
            check("spur_ready", {31'd0, req_ready}, 32'd1);
            check("spur_strobes", {28'd0, mem_req, da_read, da_write, done}, 32'd0);
        end
        @(negedge clk);
        mem_ack = 1'b0;
        mem_en = 1;
        repeat (3) @(negedge clk);
        $display("spurious ack in idle done");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/refill_writeback_unit.md
REFILL_WRITEBACK_UNIT -- requirements
Module: refill_writeback_unit

Interface
REQ-001 SHALL have parameter WORDS_PER_BLOCK, default 16, meaning 32-bit words per 64-byte line.
REQ-002 SHALL have parameter TAG_W, default 19, meaning tag width (32-bit address = 19 tag + 7 index + 6 offset).
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on the rising edge.
REQ-004 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have ports req_valid (input, 1) and req_ready (output, 1), miss-service request handshake.
REQ-006 SHALL have ports req_set (input, 7), req_way (input, 2), req_dirty (input, 1), req_victim_tag (input, TAG_W) and req_fill_tag (input, TAG_W), the request payload.
REQ-007 SHALL have port done, output, 1, a one-cycle pulse when the line is installed.
REQ-008 SHALL have memory ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, 32), mem_wdata (output, 32), mem_ack (input, 1) and mem_rdata (input, 32).
REQ-009 SHALL have data-array ports da_set_index (output, 7), da_way (output, 2), da_block_offset (output, 6), da_write_data (output, 32), da_read_data (input, 32), da_read (output, 1) and da_write (output, 1).

Function
REQ-010 SHALL implement FSM states IDLE, WB_RD, WB_CAP, WB_MEM, FL_MEM, FL_WR and DONE, with a 4-bit word counter k.
REQ-011 SHALL drive req_ready=1 only in IDLE; acceptance occurs when req_valid&&req_ready, latching the payload and clearing k to 0.
REQ-012 SHALL ignore req_valid outside IDLE, and SHALL ignore mem_ack in every state other than WB_MEM and FL_MEM.
REQ-013 On acceptance, SHALL move to WB_RD if req_dirty=1, otherwise to FL_MEM.
REQ-014 In WB_RD, SHALL set da_read=1 with da_block_offset={k,2'b00}, then go to WB_CAP.
REQ-015 In WB_CAP, SHALL latch da_read_data (one-cycle array read latency) into a write buffer, then go to WB_MEM.
REQ-016 In WB_MEM, SHALL hold mem_req=1, mem_we=1, mem_addr={victim_tag,set,k,2'b00} and mem_wdata=buffer stable until mem_ack; on ack, k=15 clears k to 0 and goes to FL_MEM, otherwise k increments and returns to WB_RD.
REQ-017 In FL_MEM, SHALL hold mem_req=1, mem_we=0 and mem_addr={fill_tag,set,k,2'b00} until mem_ack, capturing mem_rdata in the ack cycle, then go to FL_WR.
REQ-018 In FL_WR, SHALL set da_write=1 with da_write_data=captured word and da_block_offset={k,2'b00}; k=15 goes to DONE, otherwise k increments and returns to FL_MEM.
REQ-019 In DONE, SHALL assert done=1 for exactly one cycle, then return to IDLE.
REQ-020 SHALL transfer words in ascending order 0..15, and SHALL hold da_set_index and da_way at the latched set and way throughout a transaction.
REQ-021 SHALL never assert da_read and da_write in the same cycle, and SHALL never have two memory requests outstanding; mem_req SHALL drop for at least one cycle after each ack.
REQ-022 SHALL give zero-wait-memory latency (ack in first mem_req cycle) of done in the 33rd cycle after acceptance for a clean miss and the 81st for a dirty miss.
REQ-023 SHALL decode all outputs from registered state; a mem_ack arriving in the same cycle as rst SHALL be discarded.

Reset
REQ-024 While rst=1, SHALL force state IDLE, k=0, req_ready=1 (effective the cycle after rst falls), done=0, mem_req=0, mem_we=0, da_read=0 and da_write=0, with all address and data outputs at 0.
REQ-025 Reset mid-transaction SHALL abandon it without completing any further memory or array access.

Structure
REQ-026 SHALL place NUM_SETS=128, ASSOCIATIVITY=4, BLOCK_SIZE=64, WORD_SIZE=4, INDEX_W=7, TAG_W=19 and the FSM state enum in shared package cache_pkg.
REQ-027 SHALL be a single module with no sub-module, keeping the word counter inline.

Verification
REQ-028 Bench SHALL cover a clean fill: set=5, way=2, fill_tag=0x1, zero-wait memory -> 16 reads at 0x00002140..0x0000217C, 16 da_writes at offsets 0..60, done in cycle 33.
REQ-029 Bench SHALL cover a dirty miss: victim_tag=0x7FFFF, array words 0xA000_0000+k -> 16 writes to 0xFFFFE140+4k with matching data, then the fill, done in cycle 81.
REQ-030 Bench SHALL cover memory stalls: ack after 3 wait cycles per beat -> mem_addr, mem_we and mem_wdata stable while mem_req is high, with no duplicated or dropped beats.
REQ-031 Bench SHALL cover back-pressure: req_valid held high during a transaction -> no second acceptance until after done, with req_ready=0 throughout.
REQ-032 Bench SHALL cover reset at fill word 7 -> next cycle IDLE, all strobes 0, no further da_write, and a new request then completes normally.
REQ-033 Bench SHALL cover a spurious mem_ack in IDLE -> no state change and no outputs asserted.
